// File: rtl/instruction_encoder.sv
// Instruction encoder: accepts instruction fields over a valid/ready handshake, packs them into
// 16-bit words and writes them sequentially to instruction memory. Optional macro ENC_ILLEGAL_CHECK_EN.
module instruction_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [1:0]        rs_addr,
  input  logic [1:0]        rt_addr,
  input  logic [1:0]        rd_addr,
  input  logic [7:0]        immediate,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [15:0]       word_p1;
  logic              last_p1;
  logic              xfer;
  logic              illegal;

  function automatic logic [15:0] encode(input logic [3:0] op, input logic [1:0] rs,
                                         input logic [1:0] rt, input logic [1:0] rd,
                                         input logic [7:0] imm);
    logic [15:0] w;
    case (op)
      4'b0010, 4'b0100, 4'b0101, 4'b0111: w = {op, rs, rt, rd, 6'b0};
      4'b1101:                            w = {op, 2'b00, rd, 8'h00};
      default:                            w = {op, rs, rt, imm};
    endcase
    return w;
  endfunction

  assign xfer = in_valid && (state == ACCEPT);

`ifdef ENC_ILLEGAL_CHECK_EN
  assign illegal = (opcode[3:1] == 3'b111);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = ACCEPT;
      ACCEPT: if (xfer) begin
        if (illegal) state_nxt = last ? DONE : ACCEPT;
        else         state_nxt = WRITE;
      end
      WRITE:  state_nxt = (last_p1 || (&addr_q)) ? DONE : ACCEPT;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p1: encoded word captured on the handshake, written out in WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (xfer && !illegal) begin
      word_p1 <= encode(opcode, rs_addr, rt_addr, rd_addr, immediate);
      last_p1 <= last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_q  <= base_addr;
          count_q <= '0;
          err_q   <= 1'b0;
        end
        ACCEPT: if (xfer && illegal) err_q <= 1'b1;
        WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q + 1'b1;
          // running off the top of memory without a last marker ends the program in error
          if (!last_p1 && (&addr_q)) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state == ACCEPT);
    imem_we    = (state == WRITE);
    busy       = (state != IDLE);
    done       = (state == DONE);
    imem_addr  = addr_q;
    imem_wdata = word_p1;
    count      = count_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encoding, handshake timing, wrap error, reset abort
// and (when ENC_ILLEGAL_CHECK_EN is defined) the illegal-opcode path.
module tb_instruction_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [1:0]        rs_addr, rt_addr, rd_addr;
  logic [7:0]        immediate;
  logic              last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .immediate(immediate), .last(last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                            input logic [1:0] rd, input logic [7:0] imm, input logic lst);
    opcode = op; rs_addr = rs; rt_addr = rt; rd_addr = rd; immediate = imm; last = lst;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; base_addr = 0; in_valid = 0;
    set_fields(4'h0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
    step(); step();
    n_cmp++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {in_ready, imem_we, busy, done, err});
    end
    n_cmp++;
    if ({imem_addr, imem_wdata, count} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr %h data %h count %0d want 0", imem_addr, imem_wdata, count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rtype();
    start = 1; base_addr = 8'h10;
    step();
    start = 0;
    n_cmp++;
    if (in_ready !== 1 || busy !== 1 || count !== 0) begin
      n_bad++; $display("FAIL rtype_accept: ready %b busy %b count %0d want 1 1 0", in_ready, busy, count);
    end
    in_valid = 1; set_fields(4'b0010, 2'd1, 2'd2, 2'd3, 8'hA5, 1'b1);
    step();
    in_valid = 0;
    n_cmp++;
    if (imem_we !== 1 || imem_addr !== 8'h10 || imem_wdata !== 16'h26C0 || in_ready !== 0) begin
      n_bad++; $display("FAIL rtype_write: we %b addr %h data %h ready %b want 1 10 26c0 0",
                        imem_we, imem_addr, imem_wdata, in_ready);
    end
    step();
    n_cmp++;
    if (done !== 1 || imem_we !== 0 || count !== 1 || err !== 0) begin
      n_bad++; $display("FAIL rtype_done: done %b we %b count %0d err %b want 1 0 1 0", done, imem_we, count, err);
    end
    step();
    n_cmp++;
    if (done !== 0 || busy !== 0) begin
      n_bad++; $display("FAIL rtype_idle: done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_itype_move();
    start = 1; base_addr = 8'h20;
    step();
    start = 0;
    in_valid = 1; set_fields(4'b0011, 2'd2, 2'd1, 2'd0, 8'h5A, 1'b0);
    step();
    in_valid = 0;
    n_cmp++;
    if (imem_we !== 1 || imem_addr !== 8'h20 || imem_wdata !== 16'h395A) begin
      n_bad++; $display("FAIL itype_write: we %b addr %h data %h want 1 20 395a", imem_we, imem_addr, imem_wdata);
    end
    step();
    n_cmp++;
    if (in_ready !== 1 || done !== 0) begin
      n_bad++; $display("FAIL itype_back_accept: ready %b done %b want 1 0", in_ready, done);
    end
    in_valid = 1; set_fields(4'b1101, 2'd2, 2'd1, 2'd3, 8'hFF, 1'b1);
    step();
    in_valid = 0;
    n_cmp++;
    if (imem_we !== 1 || imem_addr !== 8'h21 || imem_wdata !== 16'hD300) begin
      n_bad++; $display("FAIL move_write: we %b addr %h data %h want 1 21 d300", imem_we, imem_addr, imem_wdata);
    end
    step();
    n_cmp++;
    if (done !== 1 || count !== 2) begin
      n_bad++; $display("FAIL move_done: done %b count %0d want 1 2", done, count);
    end
    step();
  endtask

  task automatic test_illegal();
    start = 1; base_addr = 8'h40;
    step();
    start = 0;
    in_valid = 1; set_fields(4'b1110, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1);
    step();
    in_valid = 0;
`ifdef ENC_ILLEGAL_CHECK_EN
    n_cmp++;
    if (imem_we !== 0 || done !== 1 || err !== 1 || count !== 0 || imem_addr !== 8'h40) begin
      n_bad++; $display("FAIL illegal_skip: we %b done %b err %b count %0d addr %h want 0 1 1 0 40",
                        imem_we, done, err, count, imem_addr);
    end
    step();
`else
    n_cmp++;
    if (imem_we !== 1 || imem_addr !== 8'h40 || imem_wdata !== 16'hE000) begin
      n_bad++; $display("FAIL op1110_write: we %b addr %h data %h want 1 40 e000", imem_we, imem_addr, imem_wdata);
    end
    step();
    n_cmp++;
    if (done !== 1 || err !== 0 || count !== 1) begin
      n_bad++; $display("FAIL op1110_done: done %b err %b count %0d want 1 0 1", done, err, count);
    end
    step();
`endif
    step();
  endtask

  task automatic test_wrap();
    start = 1; base_addr = 8'hFF;
    step();
    start = 0;
    in_valid = 1; set_fields(4'b0001, 2'd0, 2'd0, 2'd0, 8'h11, 1'b0);
    step();
    set_fields(4'b0001, 2'd1, 2'd1, 2'd1, 8'h22, 1'b0);
    n_cmp++;
    if (imem_we !== 1 || imem_addr !== 8'hFF || imem_wdata !== 16'h1011) begin
      n_bad++; $display("FAIL wrap_write: we %b addr %h data %h want 1 ff 1011", imem_we, imem_addr, imem_wdata);
    end
    step();
    n_cmp++;
    if (done !== 1 || err !== 1 || in_ready !== 0 || count !== 1 || imem_addr !== 8'h00) begin
      n_bad++; $display("FAIL wrap_done: done %b err %b ready %b count %0d addr %h want 1 1 0 1 00",
                        done, err, in_ready, count, imem_addr);
    end
    step();
    n_cmp++;
    if (in_ready !== 0 || imem_we !== 0 || busy !== 0 || err !== 1) begin
      n_bad++; $display("FAIL wrap_idle: ready %b we %b busy %b err %b want 0 0 0 1", in_ready, imem_we, busy, err);
    end
    in_valid = 0;
  endtask

  task automatic test_reset_mid_write();
    start = 1; base_addr = 8'h30;
    step();
    start = 0;
    in_valid = 1; set_fields(4'b0100, 2'd3, 2'd3, 2'd3, 8'h00, 1'b0);
    step();
    n_cmp++;
    if (imem_we !== 1 || imem_wdata !== 16'h4FC0) begin
      n_bad++; $display("FAIL abort_pre: we %b data %h want 1 4fc0", imem_we, imem_wdata);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_we, in_ready, busy, done, err, imem_addr, imem_wdata, count} !== '0) begin
      n_bad++; $display("FAIL abort_async: we %b ready %b busy %b done %b err %b addr %h data %h count %0d want all 0",
                        imem_we, in_ready, busy, done, err, imem_addr, imem_wdata, count);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (in_ready !== 0 || imem_we !== 0 || busy !== 0) begin
        n_bad++; $display("FAIL abort_hold[%0d]: ready %b we %b busy %b want 0 0 0", i, in_ready, imem_we, busy);
      end
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype_move();
    test_illegal();
    test_wrap();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction-memory address width.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  in  1  SHALL be a program-load request, sampled only in IDLE.
REQ-005 base_addr  in  ADDR_W  SHALL be the first write address, captured on start.
REQ-006 in_valid  in  1  SHALL indicate the instruction fields are valid.
REQ-007 in_ready  out  1  SHALL indicate the encoder accepts the fields this cycle.
REQ-008 opcode  in  4; rs_addr, rt_addr, rd_addr  in  2 each; immediate  in  8  SHALL be the instruction fields.
REQ-009 last  in  1  SHALL mark the final instruction of the program, qualified by the handshake.
REQ-010 imem_we  out  1; imem_addr  out  ADDR_W; imem_wdata  out  16  SHALL form the instruction-memory write port.
REQ-011 busy  out  1; done  out  1; count  out  ADDR_W+1; err  out  1  SHALL be status outputs.

Function
REQ-012 The FSM SHALL have states IDLE, ACCEPT, WRITE and DONE; busy SHALL be 1 in every state except IDLE.
REQ-013 IDLE: start=1 -> ACCEPT; address register <= base_addr; count <= 0; err <= 0; start SHALL be ignored in all other states.
REQ-014 ACCEPT: in_ready=1; a transfer SHALL occur when in_valid && in_ready; with no transfer the state SHALL be held.
REQ-015 On a transfer the encoded word and last SHALL be registered and the state SHALL go to WRITE; in_ready SHALL be 0 outside ACCEPT.
REQ-016 R-type opcodes 0010, 0100, 0101, 0111 SHALL encode as {opcode, rs_addr, rt_addr, rd_addr, 6'b0}.
REQ-017 Opcode 1101 (move) SHALL encode as {opcode, 2'b00, rd_addr, 8'h00}; rs_addr, rt_addr and immediate SHALL be ignored.
REQ-018 All other opcodes SHALL encode as {opcode, rs_addr, rt_addr, immediate}.
REQ-019 WRITE: imem_we SHALL be 1 for exactly one cycle, with imem_addr = address register and imem_wdata = registered word.
REQ-020 On leaving WRITE, the address SHALL increment modulo 2^ADDR_W and count SHALL increment by 1.
REQ-021 WRITE exit: registered last=1 -> DONE; else address all-ones (wrap) -> err <= 1, DONE; else -> ACCEPT.
REQ-022 DONE: done SHALL be 1 for exactly one cycle, then the state SHALL go to IDLE.
REQ-023 Throughput SHALL be one instruction per two cycles; latency from transfer to imem_we SHALL be one cycle.
REQ-024 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear in_ready, imem_we, imem_addr, imem_wdata, busy, done, count, err and the address register to 0.
REQ-026 Reset asserted mid-WRITE SHALL abort the write with no further imem_we pulse; the program SHALL restart only on a new start.

Configuration
REQ-027 Macro ENC_ILLEGAL_CHECK_EN defined: a transfer with opcode 1110 or 1111 SHALL set err sticky and skip WRITE, and count and address SHALL be unchanged.
REQ-028 The next state for such a transfer SHALL be DONE if last=1, else ACCEPT.
REQ-029 Macro ENC_ILLEGAL_CHECK_EN undefined: opcodes 1110 and 1111 SHALL be encoded as I-type (REQ-018) and written normally; err SHALL be set only by wrap.

Verification
REQ-030 start, base_addr=0x10; transfer opcode 0010, rs=1, rt=2, rd=3, last=1 -> imem_we at addr 0x10, data 0x26C0; done pulse; count=1.
REQ-031 Transfer opcode 0011, rs=2, rt=1, imm=0x5A -> data 0x395A; then transfer opcode 1101, rd=3, rs=2, imm=0xFF -> data 0xD300 at next address.
REQ-032 ENC_ILLEGAL_CHECK_EN defined, opcode 1110, last=1 -> no imem_we, err=1, count=0, done; macro undefined, same stimulus with imm=0x00 -> data 0xE000 written.
REQ-033 base_addr=0xFF; two instructions, last=0 -> first written at 0xFF, err=1, done; second not accepted (in_ready=0).
REQ-034 rst_n low during WRITE -> imem_we=0 and all outputs 0 at once; in_valid held with no start -> in_ready stays 0.
